// File: rtl/cell_draw_cmd_if.sv
// Request/handshake and LCD 8080 write-bus signals between the grid scanner,
// the cell draw engine and the panel.
interface cell_draw_cmd_if;
   logic       start;
   logic [3:0] x;
   logic [3:0] y;
   logic [2:0] obj_code;
   logic       busy;
   logic       cmd_done;
   logic       lcd_csx;
   logic       lcd_dcx;
   logic       lcd_wrx;
   logic [7:0] lcd_data;

   // Scanner / test side: issues requests, observes the bus.
   modport master (
      output start, x, y, obj_code,
      input  busy, cmd_done, lcd_csx, lcd_dcx, lcd_wrx, lcd_data
   );

   // Draw engine side.
   modport slave (
      input  start, x, y, obj_code,
      output busy, cmd_done, lcd_csx, lcd_dcx, lcd_wrx, lcd_data
   );
endinterface

// File: rtl/cell_draw_cmd.sv
// Cell draw engine: for one changed grid cell, sets the panel column/page
// window (CASET/PASET), issues RAMWR and streams a solid RGB565 fill.
// Every LCD output is registered so the write strobe is glitch-free.
module cell_draw_cmd #(
   parameter int CELL_PX = 20,
   parameter int GRID_W  = 16,
   parameter int GRID_H  = 12
) (
   input  logic          clk,
   input  logic          rst,
   cell_draw_cmd_if.slave bus
);

   localparam int PIX_TOTAL = CELL_PX * CELL_PX;
   localparam int PCW       = $clog2(PIX_TOTAL) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_SEND  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // Header byte indices 0..10; index 11 means "streaming pixels".
   localparam logic [3:0] HDR_PIX = 4'd11;

   logic [1:0]     state_q,   state_d;
   logic [3:0]     x_q,       x_d;
   logic [3:0]     y_q,       y_d;
   logic [2:0]     obj_q,     obj_d;
   logic [3:0]     hdr_q,     hdr_d;
   logic           phase_q,   phase_d;    // 0 = strobe low, 1 = strobe high
   logic           pix_lo_q,  pix_lo_d;   // 0 = colour high byte, 1 = low byte
   logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
   logic [PCW-1:0] pix_inc;

   logic           busy_q,    busy_d;
   logic           done_q,    done_d;
   logic           csx_q,     csx_d;
   logic           dcx_q,     dcx_d;
   logic           wrx_q,     wrx_d;
   logic [7:0]     data_q,    data_d;

   logic [15:0]    x0, x1, y0, y1;
   logic [15:0]    colour;
   logic           cell_invalid;
   logic           send_d;
   logic [8:0]     byte_d;                // {dcx, data}

   // Pixel window of the latched cell, 16-bit arithmetic.
   always_comb begin
      x0 = 16'(x_q) * 16'(CELL_PX);
      x1 = x0 + 16'(CELL_PX - 1);
      y0 = 16'(y_q) * 16'(CELL_PX);
      y1 = y0 + 16'(CELL_PX - 1);
      cell_invalid = ({12'd0, x_q} >= 16'(GRID_W)) || ({12'd0, y_q} >= 16'(GRID_H));
   end

   // RGB565 colour of the latched object code.
   always_comb begin
      case (obj_q)
         3'd0:    colour = 16'h0000;
         3'd1:    colour = 16'hFFFF;
         3'd2:    colour = 16'h07E0;
         3'd3:    colour = 16'h03E0;
         3'd4:    colour = 16'hF800;
         default: colour = 16'hF81F;
      endcase
   end

   // Sequencer: request latch, range check, byte/phase stepping, pixel count.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      obj_d     = obj_q;
      hdr_d     = hdr_q;
      phase_d   = phase_q;
      pix_lo_d  = pix_lo_q;
      pix_cnt_d = pix_cnt_q;
      pix_inc   = pix_cnt_q + PCW'(1);
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               x_d     = bus.x;
               y_d     = bus.y;
               obj_d   = bus.obj_code;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            hdr_d     = 4'd0;
            phase_d   = 1'b0;
            pix_lo_d  = 1'b0;
            pix_cnt_d = '0;
            state_d   = cell_invalid ? S_DONE : S_SEND;
         end
         S_SEND: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (hdr_q != HDR_PIX) begin
                  hdr_d = hdr_q + 4'd1;
               end else if (!pix_lo_q) begin
                  pix_lo_d = 1'b1;
               end else begin
                  pix_lo_d  = 1'b0;
                  pix_cnt_d = pix_inc;
                  if (pix_inc == PCW'(PIX_TOTAL)) begin
                     state_d = S_DONE;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Bus byte and control levels for the upcoming cycle, derived from the
   // next sequencer position so they can be registered.
   always_comb begin
      case (hdr_d)
         4'd0:    byte_d = {1'b0, 8'h2A};
         4'd1:    byte_d = {1'b1, x0[15:8]};
         4'd2:    byte_d = {1'b1, x0[7:0]};
         4'd3:    byte_d = {1'b1, x1[15:8]};
         4'd4:    byte_d = {1'b1, x1[7:0]};
         4'd5:    byte_d = {1'b0, 8'h2B};
         4'd6:    byte_d = {1'b1, y0[15:8]};
         4'd7:    byte_d = {1'b1, y0[7:0]};
         4'd8:    byte_d = {1'b1, y1[15:8]};
         4'd9:    byte_d = {1'b1, y1[7:0]};
         4'd10:   byte_d = {1'b0, 8'h2C};
         4'd11:   byte_d = pix_lo_d ? {1'b1, colour[7:0]} : {1'b1, colour[15:8]};
         default: byte_d = {1'b1, 8'h00};
      endcase
      send_d = (state_d == S_SEND);
      csx_d  = !send_d;
      wrx_d  = !(send_d && !phase_d);
      dcx_d  = send_d ? byte_d[8]   : 1'b1;
      data_d = send_d ? byte_d[7:0] : 8'h00;
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; reset aborts any request in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         obj_q     <= '0;
         hdr_q     <= '0;
         phase_q   <= 1'b0;
         pix_lo_q  <= 1'b0;
         pix_cnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         csx_q     <= 1'b1;
         dcx_q     <= 1'b1;
         wrx_q     <= 1'b1;
         data_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         obj_q     <= obj_d;
         hdr_q     <= hdr_d;
         phase_q   <= phase_d;
         pix_lo_q  <= pix_lo_d;
         pix_cnt_q <= pix_cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         csx_q     <= csx_d;
         dcx_q     <= dcx_d;
         wrx_q     <= wrx_d;
         data_q    <= data_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.cmd_done = done_q;
   assign bus.lcd_csx  = csx_q;
   assign bus.lcd_dcx  = dcx_q;
   assign bus.lcd_wrx  = wrx_q;
   assign bus.lcd_data = data_q;

endmodule

// File: tb/tb_cell_draw_cmd.sv
// Testbench for cell_draw_cmd: a negedge monitor records every latched bus
// byte and handshake event; a reference model builds the expected byte stream
// from cell coordinates and object codes.
module tb_cell_draw_cmd;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cell_draw_cmd_if bus_if();

   cell_draw_cmd #(.CELL_PX(20), .GRID_W(16), .GRID_H(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int checks   = 0;
   int failures = 0;

   // ---------------- monitor (sole writer of these variables) -------------
   int         neg_cnt   = 0;
   logic       prev_wrx  = 1'b1;
   logic       prev_busy = 1'b0;
   logic [8:0] prev_byte = 9'h100;
   logic [8:0] cur_byte;
   logic [8:0] cap_q[$];
   int         done_q[$];
   int         rise_q[$];
   int         fall_q[$];
   int         csx_low   = 0;
   int         wrx_fall  = 0;
   int         proto_err = 0;

   always @(negedge clk) begin
      neg_cnt  = neg_cnt + 1;
      cur_byte = {bus_if.lcd_dcx, bus_if.lcd_data};
      if (!bus_if.lcd_wrx && prev_wrx) wrx_fall = wrx_fall + 1;
      if (bus_if.lcd_wrx && !prev_wrx) begin
         cap_q.push_back(cur_byte);
         if (cur_byte !== prev_byte) proto_err = proto_err + 1;   // byte not held through strobe
      end
      if (!bus_if.lcd_wrx && bus_if.lcd_csx) proto_err = proto_err + 1;
      if (bus_if.lcd_csx && cur_byte !== 9'h100) proto_err = proto_err + 1;
      if (!bus_if.lcd_csx) csx_low = csx_low + 1;
      if (bus_if.cmd_done) done_q.push_back(neg_cnt);
      if (bus_if.busy && !prev_busy) rise_q.push_back(neg_cnt);
      if (!bus_if.busy && prev_busy) fall_q.push_back(neg_cnt);
      prev_wrx  = bus_if.lcd_wrx;
      prev_busy = bus_if.busy;
      prev_byte = cur_byte;
   end

   // ---------------- reference model ----------------
   logic [8:0]  exp_q[$];
   logic [15:0] colour_tab [8] = '{16'h0000, 16'hFFFF, 16'h07E0, 16'h03E0,
                                   16'hF800, 16'hF81F, 16'hF81F, 16'hF81F};

   task automatic model_push(input int cx, input int cy, input int obj);
      logic [15:0] x0, x1, y0, y1, col;
      if (cx >= 16 || cy >= 12) return;
      x0  = 16'(cx * 20);
      x1  = 16'(cx * 20 + 19);
      y0  = 16'(cy * 20);
      y1  = 16'(cy * 20 + 19);
      col = colour_tab[obj];
      exp_q.push_back({1'b0, 8'h2A});
      exp_q.push_back({1'b1, x0[15:8]}); exp_q.push_back({1'b1, x0[7:0]});
      exp_q.push_back({1'b1, x1[15:8]}); exp_q.push_back({1'b1, x1[7:0]});
      exp_q.push_back({1'b0, 8'h2B});
      exp_q.push_back({1'b1, y0[15:8]}); exp_q.push_back({1'b1, y0[7:0]});
      exp_q.push_back({1'b1, y1[15:8]}); exp_q.push_back({1'b1, y1[7:0]});
      exp_q.push_back({1'b0, 8'h2C});
      for (int p = 0; p < 400; p++) begin
         exp_q.push_back({1'b1, col[15:8]});
         exp_q.push_back({1'b1, col[7:0]});
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
      end
   endtask

   task automatic check_bus(input string tag, input int mark);
      int n;
      int bad;
      n   = cap_q.size() - mark;
      bad = -1;
      chk({tag, " byte_count"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++)
         if (bad < 0 && cap_q[mark + i] !== exp_q[i]) bad = i;
      chk({tag, " first_bad_byte_idx"}, bad, -1);
   endtask

   task automatic wait_done(input int target, input int limit, input string tag);
      int n = 0;
      while (done_q.size() < target && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " done_seen_in_time"}, done_q.size() >= target, 1);
   endtask

   function automatic int q_at(input int idx, input int which);
      if (which == 0) return (done_q.size() > idx) ? done_q[idx] : -100000;
      if (which == 1) return (rise_q.size() > idx) ? rise_q[idx] : -100000;
      return (fall_q.size() > idx) ? fall_q[idx] : -100000;
   endfunction

   // One request; inputs are scrambled right after acceptance.
   task automatic do_cell(input int cx, input int cy, input int obj, input string tag);
      int  mark, dmark, rmark, fmark, base, csx0, wf0, pe0;
      bit  valid;
      valid = (cx < 16) && (cy < 12);
      exp_q.delete();
      model_push(cx, cy, obj);
      @(negedge clk); #1;
      mark = cap_q.size(); dmark = done_q.size(); rmark = rise_q.size();
      fmark = fall_q.size(); csx0 = csx_low; wf0 = wrx_fall; pe0 = proto_err;
      bus_if.start    = 1'b1;
      bus_if.x        = 4'(cx);
      bus_if.y        = 4'(cy);
      bus_if.obj_code = 3'(obj);
      @(posedge clk); #1;
      base            = neg_cnt;
      bus_if.start    = 1'b0;
      bus_if.x        = 4'($urandom);
      bus_if.y        = 4'($urandom);
      bus_if.obj_code = 3'($urandom);
      wait_done(dmark + 1, 3000, tag);
      repeat (3) @(negedge clk);
      #1;
      chk({tag, " done_cycle"}, q_at(dmark, 0) - base, valid ? 1624 : 2);
      chk({tag, " done_pulses"}, done_q.size() - dmark, 1);
      chk({tag, " busy_rise_cycle"}, q_at(rmark, 1) - base, 1);
      chk({tag, " busy_fall_cycle"}, q_at(fmark, 2) - base, valid ? 1625 : 3);
      chk({tag, " csx_low_cycles"}, csx_low - csx0, valid ? 1622 : 0);
      chk({tag, " wrx_falls"}, wrx_fall - wf0, valid ? 811 : 0);
      chk({tag, " protocol_errs"}, proto_err - pe0, 0);
      check_bus(tag, mark);
      $display("cell x=%0d y=%0d obj=%0d bytes=%0d done_cycle=%0d", cx, cy, obj,
               cap_q.size() - mark, q_at(dmark, 0) - base);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int mark, dmark, fmark, base, n, rx, ry, ro;
      bus_if.start = 1'b0; bus_if.x = '0; bus_if.y = '0; bus_if.obj_code = '0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("reset busy", bus_if.busy, 0);
      chk("reset cmd_done", bus_if.cmd_done, 0);
      chk("reset csx", bus_if.lcd_csx, 1);
      chk("reset dcx", bus_if.lcd_dcx, 1);
      chk("reset wrx", bus_if.lcd_wrx, 1);
      chk("reset data", bus_if.lcd_data, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Main fills and boundaries
      do_cell(0, 0, 1, "x0y0_border");
      do_cell(15, 11, 4, "x15y11_apple");
      do_cell(3, 12, 2, "y12_invalid");
      do_cell(7, 4, 6, "x7y4_magenta");

      // Reset after 100 bytes of SEND aborts without cmd_done
      @(negedge clk); #1;
      mark = cap_q.size(); dmark = done_q.size();
      bus_if.start = 1'b1; bus_if.x = 4'd2; bus_if.y = 4'd3; bus_if.obj_code = 3'd1;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      n = 0;
      while (cap_q.size() - mark < 100 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("abort reached_100_bytes", cap_q.size() - mark >= 100, 1);
      #1 rst = 1'b1;
      #1;
      chk("abort csx", bus_if.lcd_csx, 1);
      chk("abort wrx", bus_if.lcd_wrx, 1);
      chk("abort busy", bus_if.busy, 0);
      chk("abort cmd_done", bus_if.cmd_done, 0);
      @(negedge clk); #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort no_done", done_q.size() - dmark, 0);
      $display("abort after %0d bytes", cap_q.size() - mark);
      do_cell(9, 6, 3, "after_abort");

      // Start held high, obj_code changed mid-transfer -> back-to-back requests
      exp_q.delete();
      model_push(5, 2, 2);
      model_push(5, 2, 3);
      @(negedge clk); #1;
      mark = cap_q.size(); dmark = done_q.size(); fmark = fall_q.size();
      bus_if.start = 1'b1; bus_if.x = 4'd5; bus_if.y = 4'd2; bus_if.obj_code = 3'd2;
      @(posedge clk); #1;
      base = neg_cnt;
      bus_if.obj_code = 3'd3;
      wait_done(dmark + 2, 5000, "held_start");
      bus_if.start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("held first_done_cycle", q_at(dmark, 0) - base, 1624);
      chk("held second_done_cycle", q_at(dmark + 1, 0) - base, 3249);
      chk("held done_pulses", done_q.size() - dmark, 2);
      chk("held busy_gap_cycle", q_at(fmark, 2) - base, 1625);
      check_bus("held_start", mark);
      $display("held start: done pulses=%0d", done_q.size() - dmark);

      // Randomized cells against the model
      for (int r = 0; r < 4; r++) begin
         rx = $urandom_range(0, 15);
         ry = $urandom_range(0, 11);
         ro = $urandom_range(0, 7);
         do_cell(rx, ry, ro, "random_valid");
      end
      do_cell($urandom_range(0, 15), $urandom_range(12, 15), $urandom_range(0, 7), "random_invalid");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
